// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcode slot codes and result-stage FIFO states
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int NUM_SRC = 16;
  localparam int OP_W = $clog2(NUM_SRC);
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SRA  = 4'd7,
    OP_NOT  = 4'd8,
    OP_PASS = 4'd9
  } op_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
endpackage

// File: rtl/alu_result_mux.sv
// alu_result_mux: picks one function-unit output word out of the flattened bus
module alu_result_mux
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int NUM_SRC = alu_pkg::NUM_SRC
) (
  input  logic [NUM_SRC*DATA_W-1:0]  mux_in,
  input  logic [$clog2(NUM_SRC)-1:0] op_sel,
  output logic [DATA_W-1:0]          selWord
);
  assign selWord = mux_in[op_sel*DATA_W +: DATA_W];
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry skid FIFO capturing the selected ALU result; ALU_FLAGS_EN adds zero/neg flags
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int NUM_SRC = alu_pkg::NUM_SRC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*DATA_W-1:0]  mux_in,
  input  logic [$clog2(NUM_SRC)-1:0] op_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_result,
  output logic [$clog2(NUM_SRC)-1:0] out_op,
`ifdef ALU_FLAGS_EN
  output logic                       out_zero,
  output logic                       out_neg,
`endif
  output logic                       out_valid,
  input  logic                       out_ready
);
  state_t state, nextState;
  logic [DATA_W-1:0] selWord, headRes, tailRes;
  logic [$clog2(NUM_SRC)-1:0] headOp, tailOp;
  logic push, pop, loadHead, loadTail, shift;
  alu_result_mux #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC)) uMux (
    .mux_in(mux_in),
    .op_sel(op_sel),
    .selWord(selWord)
  );
  // in_ready depends only on registered state and reset, never on out_ready
  assign in_ready = rst_n && (state != TWO);
  assign out_valid = state != EMPTY;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_result = headRes;
  assign out_op = headOp;
  always_comb begin
    nextState = state;
    loadHead = 1'b0;
    loadTail = 1'b0;
    shift = 1'b0;
    case (state)
      EMPTY: begin
        loadHead = push;
        nextState = push ? ONE : EMPTY;
      end
      ONE: begin
        loadHead = push && pop;
        loadTail = push && !pop;
        nextState = push ? (pop ? ONE : TWO) : (pop ? EMPTY : ONE);
      end
      TWO: begin
        shift = pop;
        nextState = pop ? ONE : TWO;
      end
      default: nextState = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      headRes <= '0;
      headOp <= '0;
      tailRes <= '0;
      tailOp <= '0;
    end else begin
      state <= nextState;
      if (loadHead) begin
        headRes <= selWord;
        headOp <= op_sel;
      end else if (shift) begin
        headRes <= tailRes;
        headOp <= tailOp;
      end
      if (loadTail) begin
        tailRes <= selWord;
        tailOp <= op_sel;
      end
    end
  end
`ifdef ALU_FLAGS_EN
  logic headZero, headNeg, tailZero, tailNeg;
  assign out_zero = headZero;
  assign out_neg = headNeg;
  // flags are taken from the word as it is captured, not from the output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      headZero <= 1'b0;
      headNeg <= 1'b0;
      tailZero <= 1'b0;
      tailNeg <= 1'b0;
    end else begin
      if (loadHead) begin
        headZero <= selWord == '0;
        headNeg <= selWord[DATA_W-1];
      end else if (shift) begin
        headZero <= tailZero;
        headNeg <= tailNeg;
      end
      if (loadTail) begin
        tailZero <= selWord == '0;
        tailNeg <= selWord[DATA_W-1];
      end
    end
  end
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: randomized check of alu_result_stage against a queue model
module tb_alu_result_stage;
  localparam int DW = 16;
  localparam int NS = 16;
  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [NS*DW-1:0] mux_in;
  logic [3:0] op_sel, out_op;
  logic [DW-1:0] out_result;
`ifdef ALU_FLAGS_EN
  logic out_zero, out_neg;
`endif
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] qRes[$];
  logic [3:0] qOp[$];
  alu_result_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .mux_in(mux_in),
    .op_sel(op_sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_result(out_result),
    .out_op(out_op),
`ifdef ALU_FLAGS_EN
    .out_zero(out_zero),
    .out_neg(out_neg),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic checkHead();
    chk("out_valid", out_valid, qRes.size() > 0);
    if (qRes.size() > 0) begin
      chk("out_result", out_result, qRes[0]);
      chk("out_op", out_op, qOp[0]);
`ifdef ALU_FLAGS_EN
      chk("out_zero", out_zero, qRes[0] == 0);
      chk("out_neg", out_neg, qRes[0][DW-1]);
`endif
    end
  endtask
  task automatic step(input logic rn, input logic iv, input logic [3:0] sel,
                      input logic [DW-1:0] val, input logic ordy);
    logic doPush, doPop;
    rst_n = rn;
    in_valid = iv;
    op_sel = sel;
    out_ready = ordy;
    for (int k = 0; k < NS; k++) mux_in[k*DW +: DW] = DW'($urandom);
    mux_in[sel*DW +: DW] = val;
    #1;
    chk("in_ready", in_ready, rn && qRes.size() < 2);
    doPush = rn && iv && qRes.size() < 2;
    doPop = rn && ordy && qRes.size() > 0;
    @(posedge clk);
    if (!rn) begin
      qRes.delete();
      qOp.delete();
    end else begin
      if (doPop) begin
        void'(qRes.pop_front());
        void'(qOp.pop_front());
      end
      if (doPush) begin
        qRes.push_back(val);
        qOp.push_back(sel);
      end
    end
    @(negedge clk);
    checkHead();
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_sel = '0;
    mux_in = '0;
    @(negedge clk);
    step(0, 1, 8, 16'h1234, 1);
    step(0, 1, 3, 16'h5678, 0);
    chk("reset_result", out_result, 0);
    chk("reset_op", out_op, 0);
    step(1, 1, 8, 16'h00FF, 1);
    chk("not_result", out_result, 16'h00FF);
    chk("not_op", out_op, 8);
    step(1, 1, 8, 16'h0000, 1);
    step(1, 1, 8, 16'h8000, 1);
    step(1, 0, 0, 16'h0, 1);
    step(1, 1, 2, 16'h1111, 0);
    step(1, 1, 5, 16'h2222, 0);
    step(1, 1, 7, 16'h3333, 0);
    chk("held_result", out_result, 16'h1111);
    step(1, 0, 0, 16'h0, 1);
    chk("drain1", out_result, 16'h2222);
    step(1, 0, 0, 16'h0, 1);
    step(1, 1, 4, 16'h5555, 0);
    step(1, 1, 9, 16'hAAAA, 1);
    chk("pushpop_result", out_result, 16'hAAAA);
    step(1, 1, 1, 16'hBEEF, 0);
    step(0, 1, 6, 16'hCAFE, 1);
    chk("midreset_result", out_result, 0);
    step(1, 0, 0, 16'h0, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, 4'($urandom),
           ($urandom_range(0, 7) == 0) ? 16'h0 : DW'($urandom), $urandom_range(0, 2) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
